// File: rtl/vector_shift_sequencer.sv
// Sequencer and two-stage pipeline around the vector integer shift unit:
// operand register (S1) feeding the shift unit, result register (S2) feeding write-back.
module vector_shift_sequencer #(
  parameter int DATA_W        = 128,
  parameter int NUM_BEATS_MAX = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              issue_valid_i,
  output logic                              issue_ready_o,
  input  logic [1:0]                        shift_type_i,
  input  logic [2:0]                        vsew_i,
  input  logic [7:0]                        vl_i,
  input  logic                              operand_valid_i,
  output logic                              operand_ready_o,
  input  logic [DATA_W-1:0]                 vs1_beat_i,
  input  logic [DATA_W-1:0]                 vs2_beat_i,
  output logic                              su_enable_o,
  output logic [1:0]                        su_shift_type_o,
  output logic [2:0]                        su_vsew_o,
  output logic [DATA_W-1:0]                 su_vs1_o,
  output logic [DATA_W-1:0]                 su_vs2_o,
  input  logic [DATA_W-1:0]                 su_vd_i,
  output logic                              wb_valid_o,
  input  logic                              wb_ready_i,
  output logic [DATA_W-1:0]                 wb_data_o,
  output logic [DATA_W/8-1:0]               wb_mask_o,
  output logic [$clog2(NUM_BEATS_MAX)-1:0]  wb_beat_o,
  output logic                              wb_last_o,
  output logic                              done_o
);

  localparam int BYTES     = DATA_W / 8;
  localparam int LOG_BYTES = $clog2(BYTES);
  localparam int BEAT_W    = $clog2(NUM_BEATS_MAX);
  localparam int CNT_W     = BEAT_W + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Beats needed for vl elements of width 8<<sew, clamped to NUM_BEATS_MAX; zero for reserved widths.
  function automatic logic [CNT_W-1:0] beat_count(input logic [2:0] sew, input logic [7:0] vl);
    int sh;
    int n;
    if (sew > 3'd3) return '0;
    sh = LOG_BYTES - int'(sew);
    n  = (int'(vl) + (1 << sh) - 1) >> sh;
    if (n > NUM_BEATS_MAX) n = NUM_BEATS_MAX;
    return CNT_W'(n);
  endfunction

  function automatic logic [BYTES-1:0] tail_mask(input logic [BEAT_W-1:0] beat,
                                                  input logic [2:0] sew,
                                                  input logic [7:0] vl);
    logic [BYTES-1:0] m;
    int idx;
    m = '0;
    for (int b = 0; b < BYTES; b++) begin
      idx  = int'(beat) * BYTES + b;
      m[b] = (idx >> sew) < int'(vl);
    end
    return m;
  endfunction

  state_t             state_q;
  logic [1:0]         shift_type_q;
  logic [2:0]         vsew_q;
  logic [7:0]         vl_q;
  logic [CNT_W-1:0]   total_q;
  logic [CNT_W-1:0]   issued_q;
  logic               done_q;

  logic [DATA_W-1:0]  vs1_p1;
  logic [DATA_W-1:0]  vs2_p1;
  logic [BEAT_W-1:0]  beat_p1;
  logic               vld_p1;

  logic [DATA_W-1:0]  vd_p2;
  logic [BYTES-1:0]   mask_p2;
  logic [BEAT_W-1:0]  beat_p2;
  logic               last_p2;
  logic               vld_p2;

  logic               stall;
  logic               issue_fire;
  logic               op_fire;
  logic               wb_fire;
  logic               last_p1;
  logic [CNT_W-1:0]   issue_cnt;

  assign stall           = vld_p2 & ~wb_ready_i;
  assign issue_ready_o   = (state_q == IDLE) & ~rst_i;
  assign operand_ready_o = (state_q == RUN) & ~stall & (issued_q < total_q) & ~rst_i;
  assign issue_fire      = issue_valid_i & issue_ready_o;
  assign op_fire         = operand_valid_i & operand_ready_o;
  assign wb_fire         = vld_p2 & wb_ready_i;
  assign issue_cnt       = beat_count(vsew_i, vl_i);
  assign last_p1         = ({1'b0, beat_p1} == (total_q - CNT_W'(1)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      shift_type_q <= '0;
      vsew_q       <= '0;
      vl_q         <= '0;
      total_q      <= '0;
      issued_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue_fire) begin
            shift_type_q <= shift_type_i;
            vsew_q       <= vsew_i;
            vl_q         <= vl_i;
            total_q      <= issue_cnt;
            issued_q     <= '0;
            // Empty instructions complete without entering RUN.
            if (issue_cnt == '0) done_q  <= 1'b1;
            else                 state_q <= RUN;
          end
        end
        RUN: begin
          if (op_fire) issued_q <= issued_q + CNT_W'(1);
          if (wb_fire && last_p2) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // S1: operand register driving the shift unit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1  <= 1'b0;
      vs1_p1  <= '0;
      vs2_p1  <= '0;
      beat_p1 <= '0;
    end else if (!stall) begin
      vld_p1 <= op_fire;
      if (op_fire) begin
        vs1_p1  <= vs1_beat_i;
        vs2_p1  <= vs2_beat_i;
        beat_p1 <= issued_q[BEAT_W-1:0];
      end
    end
  end

  // S2: write-back register holding the captured shift result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p2  <= 1'b0;
      vd_p2   <= '0;
      mask_p2 <= '0;
      beat_p2 <= '0;
      last_p2 <= 1'b0;
    end else if (!stall) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        vd_p2   <= su_vd_i;
        mask_p2 <= tail_mask(beat_p1, vsew_q, vl_q);
        beat_p2 <= beat_p1;
        last_p2 <= last_p1;
      end
    end
  end

  assign su_enable_o     = vld_p1;
  assign su_shift_type_o = shift_type_q;
  assign su_vsew_o       = vsew_q;
  assign su_vs1_o        = vs1_p1;
  assign su_vs2_o        = vs2_p1;

  assign wb_valid_o = vld_p2;
  assign wb_data_o  = vd_p2;
  assign wb_mask_o  = mask_p2;
  assign wb_beat_o  = beat_p2;
  assign wb_last_o  = last_p2;
  assign done_o     = done_q;

endmodule

// File: tb/tb_vector_shift_sequencer.sv
// Bench for vector_shift_sequencer: a behavioural shift unit closes the loop and a
// queue-based model predicts every write-back beat, its mask, and the done pulse.
module tb_vector_shift_sequencer;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         issue_valid_i;
  logic         issue_ready_o;
  logic [1:0]   shift_type_i;
  logic [2:0]   vsew_i;
  logic [7:0]   vl_i;
  logic         operand_valid_i;
  logic         operand_ready_o;
  logic [127:0] vs1_beat_i;
  logic [127:0] vs2_beat_i;
  logic         su_enable_o;
  logic [1:0]   su_shift_type_o;
  logic [2:0]   su_vsew_o;
  logic [127:0] su_vs1_o;
  logic [127:0] su_vs2_o;
  logic [127:0] su_vd_i;
  logic         wb_valid_o;
  logic         wb_ready_i;
  logic [127:0] wb_data_o;
  logic [15:0]  wb_mask_o;
  logic [2:0]   wb_beat_o;
  logic         wb_last_o;
  logic         done_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  vector_shift_sequencer #(.DATA_W(128), .NUM_BEATS_MAX(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .shift_type_i(shift_type_i), .vsew_i(vsew_i), .vl_i(vl_i),
    .operand_valid_i(operand_valid_i), .operand_ready_o(operand_ready_o),
    .vs1_beat_i(vs1_beat_i), .vs2_beat_i(vs2_beat_i),
    .su_enable_o(su_enable_o), .su_shift_type_o(su_shift_type_o), .su_vsew_o(su_vsew_o),
    .su_vs1_o(su_vs1_o), .su_vs2_o(su_vs2_o), .su_vd_i(su_vd_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
    .wb_mask_o(wb_mask_o), .wb_beat_o(wb_beat_o), .wb_last_o(wb_last_o),
    .done_o(done_o)
  );

  // Element-wise shift: element of vs2 shifted by the low bits of the matching vs1 element.
  function automatic logic [127:0] shift_ref(input logic [127:0] vs1, input logic [127:0] vs2,
                                             input logic [1:0] ty, input logic [2:0] sew);
    logic [127:0] res;
    logic [63:0]  m;
    logic [63:0]  a;
    logic [63:0]  r;
    int w;
    int sh;
    res = '0;
    if (sew > 3'd3 || ty == 2'b00) return res;
    w = 8 << sew;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    for (int e = 0; e < 128 / w; e++) begin
      a  = 64'(vs2 >> (e * w)) & m;
      sh = int'(64'(vs1 >> (e * w)) & 64'(w - 1));
      case (ty)
        2'b01:   r = (a << sh) & m;
        2'b10:   r = a >> sh;
        default: begin
          if (a[w-1]) a = a | ~m;
          r = 64'($signed(a) >>> sh) & m;
        end
      endcase
      res = res | (128'(r) << (e * w));
    end
    return res;
  endfunction

  always_comb su_vd_i = shift_ref(su_vs1_o, su_vs2_o, su_shift_type_o, su_vsew_o);

  typedef struct {
    logic [127:0] data;
    logic [15:0]  mask;
    int           beat;
    logic         last;
  } wb_t;

  wb_t expq[$];
  logic [1:0] cur_ty;
  logic [2:0] cur_sew;
  int         cur_vl;
  int         cur_total;

  function automatic int model_total(input int sew, input int vl);
    int n;
    if (sew > 3) return 0;
    n = (vl * (1 << sew) + 15) / 16;
    return (n > 8) ? 8 : n;
  endfunction

  // Body bytes are the first vl*element_bytes bytes of the register group.
  function automatic logic [15:0] model_mask(input int k);
    int nb;
    nb = cur_vl * (1 << cur_sew) - k * 16;
    if (nb < 0)  nb = 0;
    if (nb > 16) nb = 16;
    return 16'((17'd1 << nb) - 17'd1);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_instr(input logic [1:0] ty, input logic [2:0] sew, input int vl,
                           input bit rnd, input int stall_beat, input int stall_len,
                           input int stop_after);
    int sent = 0, wbn = 0, fh = -1, fw = -1, lastwb = 0, cyc = 0, stall_left;
    bit done_seen = 0;
    logic [127:0] last_vs1 = '0, last_vs2 = '0;
    wb_t b;
    stall_left = stall_len;
    cur_ty = ty; cur_sew = sew; cur_vl = vl; cur_total = model_total(int'(sew), vl);
    @(negedge clk_i);
    issue_valid_i = 1'b1; shift_type_i = ty; vsew_i = sew; vl_i = 8'(vl);
    operand_valid_i = 1'b0; wb_ready_i = 1'b1;
    #1;
    chk("issue_ready", 128'(issue_ready_o), 128'(1));
    chk("opr_idle", 128'(operand_ready_o), 128'(0));
    while (!done_seen && cyc < 300 && !(stop_after >= 0 && wbn >= stop_after)) begin
      @(negedge clk_i);
      cyc++;
      issue_valid_i = 1'b0;
      if (done_o) begin
        chk("done_timing", 128'(cyc), 128'(lastwb + 1));
        chk("beat_total", 128'(wbn), 128'(cur_total));
        chk("issue_rdy_after", 128'(issue_ready_o), 128'(1));
        done_seen = 1;
      end
      if (su_enable_o) begin
        chk("su_vs1", su_vs1_o, last_vs1);
        chk("su_vs2", su_vs2_o, last_vs2);
        chk("su_type", 128'(su_shift_type_o), 128'(cur_ty));
        chk("su_vsew", 128'(su_vsew_o), 128'(cur_sew));
      end
      if (wb_valid_o) begin
        if (fw < 0) fw = cyc;
        chk("wb_has_beat", 128'(expq.size() > 0), 128'(1));
        if (expq.size() > 0) begin
          chk("wb_data", wb_data_o, expq[0].data);
          chk("wb_mask", 128'(wb_mask_o), 128'(expq[0].mask));
          chk("wb_beat", 128'(wb_beat_o), 128'(expq[0].beat));
          chk("wb_last", 128'(wb_last_o), 128'(expq[0].last));
        end
      end
      wb_ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (wb_valid_o && int'(wb_beat_o) == stall_beat && stall_left > 0) begin
        wb_ready_i = 1'b0;
        stall_left--;
      end
      operand_valid_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      vs1_beat_i = {$urandom, $urandom, $urandom, $urandom};
      vs2_beat_i = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (wb_valid_o && !wb_ready_i) chk("opr_stall", 128'(operand_ready_o), 128'(0));
      if (sent >= cur_total) chk("opr_exhausted", 128'(operand_ready_o), 128'(0));
      if (wb_valid_o && wb_ready_i && expq.size() > 0) begin
        void'(expq.pop_front());
        wbn++;
        lastwb = cyc;
      end
      if (operand_valid_i && operand_ready_o) begin
        if (fh < 0) fh = cyc;
        b.data = shift_ref(vs1_beat_i, vs2_beat_i, cur_ty, cur_sew);
        b.mask = model_mask(sent);
        b.beat = sent;
        b.last = (sent == cur_total - 1);
        expq.push_back(b);
        last_vs1 = vs1_beat_i;
        last_vs2 = vs2_beat_i;
        sent++;
      end
    end
    if (stop_after < 0 && !done_seen) chk("done_timeout", 128'(0), 128'(done_seen ? 0 : 1) ^ 128'(1));
    if (fh >= 0) chk("latency", 128'(fw - fh), 128'(2));
    operand_valid_i = 1'b0;
    wb_ready_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1; issue_valid_i = 1'b0; shift_type_i = '0; vsew_i = '0; vl_i = '0;
    operand_valid_i = 1'b0; vs1_beat_i = '0; vs2_beat_i = '0; wb_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_issue_ready", 128'(issue_ready_o), 128'(0));
    chk("rst_wb_valid", 128'(wb_valid_o), 128'(0));
    chk("rst_su_enable", 128'(su_enable_o), 128'(0));
    chk("rst_done", 128'(done_o), 128'(0));
    chk("rst_wb_data", wb_data_o, 128'(0));
    rst_i = 1'b0;
    #1;
    chk("post_rst_issue_ready", 128'(issue_ready_o), 128'(1));

    run_instr(2'b01, 3'd0, 32, 0, -1, 0, -1);   // 8-bit sll, 2 beats
    run_instr(2'b11, 3'd2, 5, 0, -1, 0, -1);    // 32-bit sra, tail mask 0x000F
    run_instr(2'b10, 3'd1, 64, 0, 2, 3, -1);    // 16-bit srl, stall on beat 2
    run_instr(2'b01, 3'd0, 0, 0, -1, 0, -1);    // vl=0
    run_instr(2'b01, 3'd5, 10, 0, -1, 0, -1);   // reserved vsew
    run_instr(2'b01, 3'd0, 200, 0, -1, 0, -1);  // clamp to 8 beats
    run_instr(2'b00, 3'd3, 9, 0, -1, 0, -1);    // no-op shift type, 64-bit

    // Reset in the middle of a 4-beat instruction
    run_instr(2'b01, 3'd0, 64, 0, -1, 0, 1);
    @(negedge clk_i);
    rst_i = 1'b1; operand_valid_i = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_issue_ready", 128'(issue_ready_o), 128'(0));
    chk("mid_rst_opr_ready", 128'(operand_ready_o), 128'(0));
    chk("mid_rst_su_enable", 128'(su_enable_o), 128'(0));
    chk("mid_rst_su_vs1", su_vs1_o, 128'(0));
    chk("mid_rst_su_vs2", su_vs2_o, 128'(0));
    chk("mid_rst_su_type", 128'(su_shift_type_o), 128'(0));
    chk("mid_rst_su_vsew", 128'(su_vsew_o), 128'(0));
    chk("mid_rst_wb_valid", 128'(wb_valid_o), 128'(0));
    chk("mid_rst_wb_data", wb_data_o, 128'(0));
    chk("mid_rst_wb_mask", 128'(wb_mask_o), 128'(0));
    chk("mid_rst_wb_beat", 128'(wb_beat_o), 128'(0));
    chk("mid_rst_wb_last", 128'(wb_last_o), 128'(0));
    chk("mid_rst_done", 128'(done_o), 128'(0));
    rst_i = 1'b0;
    expq.delete();
    @(negedge clk_i);
    chk("after_rst_done", 128'(done_o), 128'(0));
    chk("after_rst_issue_ready", 128'(issue_ready_o), 128'(1));
    run_instr(2'b10, 3'd0, 64, 0, -1, 0, -1);

    // Randomized instructions with random back-pressure and operand gaps
    for (int i = 0; i < 8; i++) begin
      run_instr(2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                1, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
